// File: rtl/freq_duty_monitor.sv
// rtl/freq_duty_monitor.sv - divided-clock period/high-time monitor with lock and stall detection (optional DUTY_CHECK_EN)
module freq_duty_monitor #(
    parameter int CNT_W         = 16,
    parameter int EXPECT_PERIOD = 5,
    parameter int LOCK_COUNT    = 4,
    parameter int MAX_COUNT     = 255,
    parameter int HIGH_MIN      = 2,
    parameter int HIGH_MAX      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_COUNT);
    localparam logic [CNT_W-1:0] EXP_P  = CNT_W'(EXPECT_PERIOD);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
    localparam logic [3:0]       LOCK_C = 4'(LOCK_COUNT);

    state_t           state, state_nx;
    logic             s1, s2, s3;
    logic             rise, fall;
    logic [CNT_W-1:0] cnt, hi_tmp;
    logic [3:0]       match_cnt, match_inc;
    logic             load_cnt, take_meas, capture_hi, timeout, clear_stall;
    logic             duty_ok, meas_match;

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

`ifdef DUTY_CHECK_EN
    assign duty_ok = (hi_tmp >= CNT_W'(HIGH_MIN)) && (hi_tmp <= CNT_W'(HIGH_MAX));
`else
    // Duty never gates lock in this build; the range parameters stay referenced only.
    assign duty_ok = 1'b1 | (HIGH_MIN > HIGH_MAX);
`endif

    assign meas_match = (cnt == EXP_P) && duty_ok;
    assign match_inc  = (match_cnt >= LOCK_C) ? LOCK_C : match_cnt + 4'd1;

    always_comb begin
        state_nx    = state;
        load_cnt    = 1'b0;
        take_meas   = 1'b0;
        capture_hi  = 1'b0;
        timeout     = 1'b0;
        clear_stall = 1'b0;
        if (!en) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        load_cnt    = 1'b1;
                        clear_stall = 1'b1;
                        state_nx    = HIGH;
                    end
                end
                HIGH: begin
                    if (cnt == MAX_C) begin
                        timeout  = 1'b1;
                        state_nx = IDLE;
                    end else if (fall) begin
                        capture_hi = 1'b1;
                        state_nx   = LOW;
                    end
                end
                LOW: begin
                    // A rise coinciding with the timeout still completes the measurement.
                    if (rise) begin
                        take_meas = 1'b1;
                        load_cnt  = 1'b1;
                        state_nx  = HIGH;
                    end else if (cnt == MAX_C) begin
                        timeout  = 1'b1;
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            state      <= IDLE;
            cnt        <= '0;
            hi_tmp     <= '0;
            match_cnt  <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            stall      <= 1'b0;
        end else begin
            s1         <= sig_in;
            s2         <= s1;
            s3         <= s2;
            state      <= state_nx;
            meas_valid <= 1'b0;

            if (load_cnt)
                cnt <= ONE_C;
            else if (cnt < MAX_C)
                cnt <= cnt + ONE_C;

            if (capture_hi)
                hi_tmp <= cnt;

            if (take_meas) begin
                period     <= cnt;
                high_time  <= hi_tmp;
                meas_valid <= 1'b1;
                if (meas_match) begin
                    match_cnt <= match_inc;
                    locked    <= (match_inc == LOCK_C);
                end else begin
                    match_cnt <= '0;
                    locked    <= 1'b0;
                end
            end

            if (timeout) begin
                stall     <= 1'b1;
                locked    <= 1'b0;
                match_cnt <= '0;
            end

            if (clear_stall)
                stall <= 1'b0;
        end
    end

endmodule

// File: tb/tb_freq_duty_monitor.sv
// tb/tb_freq_duty_monitor.sv - scoreboard bench for freq_duty_monitor
module tb_freq_duty_monitor;

    localparam int EXP_P    = 5;
    localparam int LOCK_N   = 4;
    localparam int MAX_C    = 255;
    localparam int H_MIN    = 2;
    localparam int H_MAX    = 3;

    logic        clk = 1'b0;
    logic        rst, en, sig_in;
    logic [15:0] period, high_time;
    logic        meas_valid, locked, stall;

    freq_duty_monitor dut (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
        .period(period), .high_time(high_time),
        .meas_valid(meas_valid), .locked(locked), .stall(stall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int p;
        int h;
        bit lk;
    } exp_t;

    exp_t sb[$];
    bit   hist[$];
    int   checks   = 0;
    int   failures = 0;
    bit   have_prev = 0;
    int   ph, pl, rise_cyc, k;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic bit is_match(input int p, input int h);
`ifdef DUTY_CHECK_EN
        return (p == EXP_P) && (h >= H_MIN) && (h <= H_MAX);
`else
        return (p == EXP_P) && (h >= 0);
`endif
    endfunction

    // Lock holds when the last LOCK_N completed periods since any break were all on target.
    task automatic push_exp(input int p, input int h);
        exp_t e;
        if (is_match(p, h)) hist.push_back(1'b1);
        else hist.delete();
        e.p  = p;
        e.h  = h;
        e.lk = (hist.size() >= LOCK_N);
        sb.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_period(input int h, input int l);
        if (have_prev) push_exp(ph + pl, ph);
        have_prev = 1'b1;
        ph = h;
        pl = l;
        sig_in = 1'b1;
        rise_cyc = cyc;
        repeat (h) tick();
        sig_in = 1'b0;
        repeat (l) tick();
    endtask

    task automatic check_zero(input string name);
        check(name, {period, high_time, meas_valid, locked, stall}, 0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && meas_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_meas", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("period", period, e.p);
                    check("high_time", high_time, e.h);
                    check("locked", locked, e.lk);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        en = 1'b0;
        sig_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            sig_in = ~sig_in;
            check_zero("reset_outputs");
        end
        rst = 1'b0;
        sig_in = 1'b0;
        tick();
        check_zero("post_reset_outputs");
        repeat (3) tick();
        en = 1'b1;
        repeat (2) tick();

        repeat (8) drive_period(3, 2);

        drive_period(3, 3);
        repeat (6) drive_period(3, 2);

        repeat (6) drive_period(4, 1);
        repeat (5) drive_period(3, 2);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0) drive_period(3, 2);
            else drive_period($urandom_range(1, 5), $urandom_range(1, 5));
        end
        repeat (6) drive_period(3, 2);
        check("locked_before_stall", locked, 1);

        drive_period(3, 1);
        k = rise_cyc;
        for (int n = 0; n < 400 && !stall; n++) tick();
        check("stall_seen", stall, 1);
        check("stall_delay", cyc - k, MAX_C + 3);
        check("locked_at_stall", locked, 0);
        repeat (40) tick();
        check("stall_held", stall, 1);
        have_prev = 1'b0;
        hist.delete();

        have_prev = 1'b1;
        ph = 3;
        pl = 2;
        sig_in = 1'b1;
        k = cyc;
        tick();
        tick();
        check("stall_before_rise_seen", stall, 1);
        tick();
        check("stall_cleared", stall, 0);
        sig_in = 1'b0;
        tick();
        tick();
        repeat (6) drive_period(3, 2);

        if (have_prev) push_exp(ph + pl, ph);
        sig_in = 1'b1;
        repeat (3) tick();
        sig_in = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        have_prev = 1'b0;
        hist.delete();
        check_zero("midop_reset_outputs");
        repeat (2) tick();
        drive_period(3, 2);
        check("period_zero_after_reset", period, 0);
        check("high_zero_after_reset", high_time, 0);
        repeat (6) drive_period(3, 2);

        repeat (12) tick();
        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
